stream_rr_arbiter: RTL and testbench

Packet-aware round-robin arbiter that merges `NUM_IN` valid/ready streams onto one output stream. It is the N-to-1 counterpart to the stream fork/join blocks, and shares a single downstream consumer among several producers. The arbiter has zero-latency pass-through from the granted input to the output. The grant is held stable while the output is stalled and, optionally, until the end of a packet (`last`).

---
 rtl/stream_pkg.sv | 22 ++
 rtl/stream_rr_pick.sv | 33 +++
 rtl/stream_rr_arbiter.sv | 109 ++++++++++
 tb/tb_stream_rr_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared stream types and helpers.
// Used by the stream arbiter slice.
package stream_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width for n streams, never below 1 bit.
  function automatic int id_wd(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Circular first-one finder starting at ptr.
// Doubled request vector, masked below ptr, lowest bit isolated.
module stream_rr_pick
  import stream_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_wd(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] msk;
  logic [2*N-1:0] low;

  // Mask off bits below ptr, keep lowest survivor, fold back to index.
  always_comb begin
    dbl   = {req_i, req_i};
    msk   = dbl & ({(2*N){1'b1}} << ptr_i);
    low   = msk & (~msk + ONE);
    idx_o = ptr_i;
    for (int j = 0; j < 2*N; j++) begin
      if (low[j]) idx_o = IW'(j % N);
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin N:1 stream arbiter.
// Zero-latency pass-through; grant held on stall and through packets.
module stream_rr_arbiter
  import stream_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int DATA_WD  = 32,
  parameter int LOCK_PKT = 1,
  parameter int ID_WD    = id_wd(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_IN*DATA_WD-1:0] s_data,
  input  logic [NUM_IN-1:0]         s_valid,
  input  logic [NUM_IN-1:0]         s_last,
  output logic [NUM_IN-1:0]         s_ready,
  output logic [DATA_WD-1:0]        m_data,
  output logic                      m_valid,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic [ID_WD-1:0]          m_id
);

  arb_state_e       state_q, state_d;
  logic [ID_WD-1:0] ptr_q, ptr_d;
  logic [ID_WD-1:0] gnt_q, gnt_d;
  logic [ID_WD-1:0] pick;
  logic             pick_any;
  logic [ID_WD-1:0] gnt;
  logic             sel_v;
  logic             fire;

  function automatic logic [ID_WD-1:0] inc(input logic [ID_WD-1:0] p);
    return (p == ID_WD'(NUM_IN-1)) ? '0 : p + ID_WD'(1);
  endfunction

  stream_rr_pick #(
    .N  (NUM_IN),
    .IW (ID_WD)
  ) u_pick (
    .req_i (s_valid),
    .ptr_i (ptr_q),
    .idx_o (pick),
    .any_o (pick_any)
  );

  // Output mux following the current grant; gated while in reset.
  always_comb begin
    gnt     = (state_q == ARB_BUSY) ? gnt_q : pick;
    sel_v   = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    s_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (ID_WD'(i) == gnt) begin
        sel_v      = s_valid[i];
        m_last     = s_last[i];
        m_data     = s_data[i*DATA_WD +: DATA_WD];
        s_ready[i] = m_ready & rstn;
      end
    end
    m_valid = rstn & ((state_q == ARB_IDLE) ? pick_any : sel_v);
    m_id    = gnt;
    fire    = m_valid & m_ready;
  end

  // Next state: lock grant on stall or open packet, advance ptr on release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m_valid && !m_ready) begin
          state_d = ARB_BUSY;
          gnt_d   = gnt;
        end else if (fire) begin
          if ((LOCK_PKT != 0) && !m_last) begin
            state_d = ARB_BUSY;
            gnt_d   = gnt;
          end else begin
            ptr_d = inc(gnt);
          end
        end
      end
      ARB_BUSY: begin
        if (fire && (m_last || (LOCK_PKT == 0))) begin
          state_d = ARB_IDLE;
          ptr_d   = inc(gnt_q);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State, pointer and latched grant registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter.
// Covers locked, unlocked and 3-input variants.
module tb_stream_rr_arbiter;

  logic         clk;
  logic         rstn;
  logic [127:0] s_data;
  logic [3:0]   s_valid;
  logic [3:0]   s_last;
  logic         m_ready;

  logic [3:0]   a_srdy, b_srdy;
  logic [2:0]   c_srdy;
  logic [31:0]  a_data, b_data, c_data;
  logic         a_mv, b_mv, c_mv;
  logic         a_ml, b_ml, c_ml;
  logic [1:0]   a_id, b_id, c_id;

  int errs;
  int nchk;

  stream_rr_arbiter #(.NUM_IN(4), .DATA_WD(32), .LOCK_PKT(1)) u_a (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(a_srdy), .m_data(a_data),
    .m_valid(a_mv), .m_last(a_ml), .m_ready(m_ready), .m_id(a_id)
  );

  stream_rr_arbiter #(.NUM_IN(4), .DATA_WD(32), .LOCK_PKT(0)) u_b (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(b_srdy), .m_data(b_data),
    .m_valid(b_mv), .m_last(b_ml), .m_ready(m_ready), .m_id(b_id)
  );

  stream_rr_arbiter #(.NUM_IN(3), .DATA_WD(32), .LOCK_PKT(1)) u_c (
    .clk(clk), .rstn(rstn), .s_data(s_data[95:0]),
    .s_valid(s_valid[2:0]), .s_last(s_last[2:0]), .s_ready(c_srdy),
    .m_data(c_data), .m_valid(c_mv), .m_last(c_ml),
    .m_ready(m_ready), .m_id(c_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic r, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3);
    @(posedge clk);
    #1;
    s_valid = v;
    s_last  = l;
    m_ready = r;
    s_data  = {d3, d2, d1, d0};
    #3;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    s_valid = 4'hF;
    s_last  = 4'hF;
    m_ready = 1'b1;
    #1;
    chk("rst_mvalid", {31'd0, a_mv}, 32'd0);
    chk("rst_sready", {28'd0, a_srdy}, 32'd0);
    s_valid = 4'h0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    errs    = 0;
    nchk    = 0;
    rstn    = 1'b0;
    s_data  = '0;
    s_valid = '0;
    s_last  = '0;
    m_ready = 1'b0;
    do_reset();

    // Fairness, locked, single-beat packets
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 4'hF, 1'b1, 32'h0, 32'h1, 32'h2, 32'h3);
      chk("rr_id", {30'd0, a_id}, i % 4);
      chk("rr_srdy", {28'd0, a_srdy}, 32'd1 << (i % 4));
      chk("rr_data", a_data, i % 4);
    end

    // Locked 3-beat packet on stream 2 with a bubble
    drive(4'b0101, 4'b0001, 1'b1, 32'h10, 32'h0, 32'hA0, 32'h0);
    chk("pk_id0", {30'd0, a_id}, 32'd2);
    chk("pk_d0", a_data, 32'hA0);
    chk("pk_l0", {31'd0, a_ml}, 32'd0);
    drive(4'b0101, 4'b0001, 1'b1, 32'h10, 32'h0, 32'hA1, 32'h0);
    chk("pk_id1", {30'd0, a_id}, 32'd2);
    chk("pk_d1", a_data, 32'hA1);
    drive(4'b0001, 4'b0001, 1'b1, 32'h10, 32'h0, 32'h0, 32'h0);
    chk("pk_bub_id", {30'd0, a_id}, 32'd2);
    chk("pk_bub_v", {31'd0, a_mv}, 32'd0);
    drive(4'b0101, 4'b0101, 1'b1, 32'h10, 32'h0, 32'hA2, 32'h0);
    chk("pk_id2", {30'd0, a_id}, 32'd2);
    chk("pk_d2", a_data, 32'hA2);
    chk("pk_l2", {31'd0, a_ml}, 32'd1);
    drive(4'b0001, 4'b0001, 1'b1, 32'h10, 32'h0, 32'h0, 32'h0);
    chk("pk_after", {30'd0, a_id}, 32'd0);
    chk("pk_after_d", a_data, 32'h10);

    // Unlocked: beats interleave
    do_reset();
    drive(4'b0101, 4'b0001, 1'b1, 32'h10, 32'h0, 32'hA0, 32'h0);
    chk("nl_id0", {30'd0, b_id}, 32'd0);
    drive(4'b0101, 4'b0001, 1'b1, 32'h10, 32'h0, 32'hA0, 32'h0);
    chk("nl_id1", {30'd0, b_id}, 32'd2);
    chk("nl_d1", b_data, 32'hA0);
    drive(4'b0101, 4'b0001, 1'b1, 32'h10, 32'h0, 32'hA1, 32'h0);
    chk("nl_id2", {30'd0, b_id}, 32'd0);
    chk("nl_d2", b_data, 32'h10);
    drive(4'b0101, 4'b0001, 1'b1, 32'h10, 32'h0, 32'hA1, 32'h0);
    chk("nl_id3", {30'd0, b_id}, 32'd2);
    chk("nl_d3", b_data, 32'hA1);
    drive(4'b0101, 4'b0101, 1'b1, 32'h10, 32'h0, 32'hA2, 32'h0);
    chk("nl_id4", {30'd0, b_id}, 32'd0);
    drive(4'b0101, 4'b0101, 1'b1, 32'h10, 32'h0, 32'hA2, 32'h0);
    chk("nl_id5", {30'd0, b_id}, 32'd2);
    chk("nl_d5", b_data, 32'hA2);

    // Stall hold: stream 3 pending, stream 0 arrives
    do_reset();
    drive(4'b1000, 4'b1000, 1'b0, 32'h10, 32'h0, 32'h0, 32'h33);
    chk("st_id0", {30'd0, a_id}, 32'd3);
    chk("st_d0", a_data, 32'h33);
    chk("st_v0", {31'd0, a_mv}, 32'd1);
    chk("st_srdy0", {28'd0, a_srdy}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      drive(4'b1001, 4'b1001, 1'b0, 32'h10, 32'h0, 32'h0, 32'h33);
      chk("st_id", {30'd0, a_id}, 32'd3);
      chk("st_d", a_data, 32'h33);
    end
    drive(4'b1001, 4'b1001, 1'b1, 32'h10, 32'h0, 32'h0, 32'h33);
    chk("st_fire_id", {30'd0, a_id}, 32'd3);
    chk("st_fire_srdy", {28'd0, a_srdy}, 32'b1000);
    drive(4'b0001, 4'b0001, 1'b1, 32'h10, 32'h0, 32'h0, 32'h0);
    chk("st_next_id", {30'd0, a_id}, 32'd0);

    // Reset mid-packet on stream 1
    drive(4'b0010, 4'b0000, 1'b1, 32'h0, 32'h21, 32'h0, 32'h0);
    chk("mr_id0", {30'd0, a_id}, 32'd1);
    drive(4'b0010, 4'b0000, 1'b1, 32'h0, 32'h22, 32'h0, 32'h0);
    chk("mr_d1", a_data, 32'h22);
    rstn = 1'b0;
    #1;
    chk("mr_mvalid", {31'd0, a_mv}, 32'd0);
    chk("mr_sready", {28'd0, a_srdy}, 32'd0);
    s_valid = 4'h0;
    m_ready = 1'b0;
    #2;
    rstn = 1'b1;
    drive(4'hF, 4'hF, 1'b1, 32'h0, 32'h1, 32'h2, 32'h3);
    chk("mr_restart0", {30'd0, a_id}, 32'd0);
    drive(4'hF, 4'hF, 1'b1, 32'h0, 32'h1, 32'h2, 32'h3);
    chk("mr_restart1", {30'd0, a_id}, 32'd1);

    // Three-input wrap
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 4'hF, 1'b1, 32'h0, 32'h1, 32'h2, 32'h3);
      chk("w3_id", {30'd0, c_id}, i % 3);
      chk("w3_srdy", {29'd0, c_srdy}, 32'd1 << (i % 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
